// File: rtl/add_hdr_q.sv
// Length-header inserter: buffers whole packets, prepends a header word with
// word/byte counts, drops oversize packets and queues several packets.
module add_hdr_q #(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH/8,
  parameter int STAGE_NUMBER    = 'hff,
  parameter int PORT_NUMBER     = 0,
  parameter int MAX_PKT_BYTES   = 2048,
  parameter int DATA_FIFO_DEPTH = 512,
  parameter int LEN_FIFO_DEPTH  = 8,
  localparam int LAW            = $clog2(LEN_FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic [15:0]           drop_cnt,
  output logic [LAW:0]          pkts_queued
);
  localparam int AW = $clog2(DATA_FIFO_DEPTH);
  localparam int MW = CTRL_WIDTH + DATA_WIDTH;
  localparam logic [15:0] MAXW = 16'(MAX_PKT_BYTES / CTRL_WIDTH);
  localparam logic [15:0] CW16 = 16'(CTRL_WIDTH);
  localparam logic [AW:0] A1 = 1;
  localparam logic [LAW:0] L1 = 1;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  function automatic logic [15:0] eop_bytes(
    input logic [CTRL_WIDTH-1:0] c
  );
    eop_bytes = '0;
    for (int i = CTRL_WIDTH-1; i >= 0; i--)
      if (c[i]) eop_bytes = 16'(CTRL_WIDTH - i);
  endfunction

  logic [MW-1:0] mem [DATA_FIFO_DEPTH];
  logic [31:0]   lmem [LEN_FIFO_DEPTH];

  logic [AW:0]  wr_q, wr_d, cm_q, cm_d, rd_q, rd_d;
  logic [LAW:0] lwr_q, lwr_d, lrd_q, lrd_d;
  logic [LAW:0] lcnt_q, lcnt_d;
  logic [15:0]  wcnt_q, wcnt_d, drop_q, drop_d;
  logic         dmode_q, dmode_d;
  state_t       st_q, st_d;

  logic [AW:0]   used;
  logic          data_full, len_full, acc, eop, over;
  logic          wen, len_push, len_pop, rd_pop, avail;
  logic [15:0]   pkt_bytes, drop_inc;
  logic [MW-1:0] head;
  logic [31:0]   lhead;

  assign used      = wr_q - rd_q;
  assign data_full = used == (AW+1)'(DATA_FIFO_DEPTH);
  assign len_full  = lcnt_q == (LAW+1)'(LEN_FIFO_DEPTH);
  assign in_rdy    = dmode_q | (!data_full & !len_full);
  assign acc       = in_wr & in_rdy;
  assign eop       = |in_ctrl;
  // A packet already at the word limit cannot take one more word.
  assign over      = wcnt_q >= MAXW;
  assign wen       = acc & !dmode_q & !over;
  assign len_push  = wen & eop;
  assign pkt_bytes = CW16 * wcnt_q + eop_bytes(in_ctrl);
  assign drop_inc  = (drop_q == 16'hffff) ? drop_q : drop_q + 16'd1;

  assign head  = mem[rd_q[AW-1:0]];
  assign lhead = lmem[lrd_q[LAW-1:0]];
  assign avail = rd_q != cm_q;

  always_comb begin
    wr_d    = wr_q;
    cm_d    = cm_q;
    wcnt_d  = wcnt_q;
    dmode_d = dmode_q;
    drop_d  = drop_q;
    lwr_d   = lwr_q;
    if (acc) begin
      if (dmode_q) begin
        if (eop) begin
          dmode_d = 1'b0;
          drop_d  = drop_inc;
          wcnt_d  = '0;
        end
      end else if (over) begin
        wr_d   = cm_q;
        wcnt_d = '0;
        if (eop) drop_d = drop_inc;
        else dmode_d = 1'b1;
      end else begin
        wr_d   = wr_q + A1;
        wcnt_d = wcnt_q + 16'd1;
        if (eop) begin
          cm_d   = wr_q + A1;
          wcnt_d = '0;
          lwr_d  = lwr_q + L1;
        end
      end
    end
  end

  always_comb begin
    st_d     = st_q;
    out_wr   = 1'b0;
    out_data = '0;
    out_ctrl = '0;
    len_pop  = 1'b0;
    rd_pop   = 1'b0;
    unique case (st_q)
      IDLE: if (lcnt_q != '0) st_d = HDR;
      HDR: begin
        out_data = {{(DATA_WIDTH-48){1'b0}}, lhead[31:16],
                    16'(PORT_NUMBER), lhead[15:0]};
        out_ctrl = CTRL_WIDTH'(STAGE_NUMBER);
        out_wr   = out_rdy;
        if (out_rdy) begin
          len_pop = 1'b1;
          st_d    = DATA;
        end
      end
      DATA: begin
        out_data = head[DATA_WIDTH-1:0];
        out_ctrl = head[MW-1:DATA_WIDTH];
        rd_pop   = out_rdy & avail;
        out_wr   = rd_pop;
        if (rd_pop && head[MW-1:DATA_WIDTH] != '0)
          st_d = (lcnt_q != '0 || len_push) ? HDR : IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  assign rd_d   = rd_pop ? rd_q + A1 : rd_q;
  assign lrd_d  = len_pop ? lrd_q + L1 : lrd_q;
  assign lcnt_d = lcnt_q + (len_push ? L1 : '0) - (len_pop ? L1 : '0);

  always_ff @(posedge clk) begin
    if (wen) mem[wr_q[AW-1:0]] <= {in_ctrl, in_data};
    if (len_push) lmem[lwr_q[LAW-1:0]] <= {wcnt_q + 16'd1, pkt_bytes};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      cm_q    <= '0;
      rd_q    <= '0;
      lwr_q   <= '0;
      lrd_q   <= '0;
      lcnt_q  <= '0;
      wcnt_q  <= '0;
      drop_q  <= '0;
      dmode_q <= 1'b0;
      st_q    <= IDLE;
    end else begin
      wr_q    <= wr_d;
      cm_q    <= cm_d;
      rd_q    <= rd_d;
      lwr_q   <= lwr_d;
      lrd_q   <= lrd_d;
      lcnt_q  <= lcnt_d;
      wcnt_q  <= wcnt_d;
      drop_q  <= drop_d;
      dmode_q <= dmode_d;
      st_q    <= st_d;
    end
  end

  assign drop_cnt    = drop_q;
  assign pkts_queued = lcnt_q;
endmodule
